// File: rtl/spi_cmd_pkg.sv
// Command codes, parser state encoding and reset defaults for the SPI command parser.
package spi_cmd_pkg;

  localparam logic [7:0] CMD_CONF_WR = 8'h2A;
  localparam logic [7:0] CMD_ADDR_WR = 8'h2B;
  localparam logic [7:0] CMD_DATA_WR = 8'h2C;
  localparam logic [7:0] CMD_REFRESH = 8'h2D;

  localparam logic [7:0] T0H_RST     = 8'd10;
  localparam logic [7:0] T1H_RST     = 8'd30;
  localparam logic [7:0] TBIT_RST    = 8'd60;
  localparam logic [7:0] LED_NUM_RST = 8'd64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONF,
    ST_ADDR,
    ST_DATA,
    ST_DISCARD
  } state_e;

endpackage

// File: rtl/spi_cmd_parser.sv
// Byte-stream command parser: decodes SPI frames into LED-RAM writes, bit-timing
// configuration and refresh requests.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for the command byte of a frame
// ST_CONF    | collecting t0h, t1h, tbit, led_num into shadow registers
// ST_ADDR    | collecting the big-endian 12-bit RAM address
// ST_DATA    | writing every received byte to RAM, address auto-increments
// ST_DISCARD | ignoring bytes until CS deasserts
module spi_cmd_parser
  import spi_cmd_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        spi_cs_in,
  input  logic        byte_rdy_in,
  input  logic [7:0]  byte_data_in,
  output logic        ram_wr_en_out,
  output logic [11:0] ram_wr_addr_out,
  output logic [7:0]  ram_wr_data_out,
  output logic [7:0]  t0h_time_out,
  output logic [7:0]  t1h_time_out,
  output logic [7:0]  tbit_time_out,
  output logic [7:0]  led_num_out,
  output logic        refresh_out
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  sh_t0h_q, sh_t0h_d;
  logic [7:0]  sh_t1h_q, sh_t1h_d;
  logic [7:0]  sh_tbit_q, sh_tbit_d;
  logic [3:0]  sh_addr_hi_q, sh_addr_hi_d;
  logic [11:0] addr_q, addr_d;
  logic        wr_en_q, wr_en_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        refresh_q, refresh_d;
  logic [7:0]  t0h_q, t0h_d, t1h_q, t1h_d, tbit_q, tbit_d, led_num_q, led_num_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_t0h_d     = sh_t0h_q;
    sh_t1h_d     = sh_t1h_q;
    sh_tbit_d    = sh_tbit_q;
    sh_addr_hi_d = sh_addr_hi_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    refresh_d    = 1'b0;
    t0h_d        = t0h_q;
    t1h_d        = t1h_q;
    tbit_d       = tbit_q;
    led_num_d    = led_num_q;

    // CS low wins over a coincident byte so a torn frame never commits.
    if (!spi_cs_in) begin
      state_d = ST_IDLE;
      cnt_d   = 2'd0;
    end else if (byte_rdy_in) begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = 2'd0;
          case (byte_data_in)
            CMD_CONF_WR: state_d = ST_CONF;
            CMD_ADDR_WR: state_d = ST_ADDR;
            CMD_DATA_WR: state_d = ST_DATA;
            CMD_REFRESH: begin
              refresh_d = 1'b1;
              state_d   = ST_DISCARD;
            end
            default:     state_d = ST_DISCARD;
          endcase
        end
        ST_CONF: begin
          cnt_d = cnt_q + 2'd1;
          case (cnt_q)
            2'd0: sh_t0h_d  = byte_data_in;
            2'd1: sh_t1h_d  = byte_data_in;
            2'd2: sh_tbit_d = byte_data_in;
            default: begin
              t0h_d     = sh_t0h_q;
              t1h_d     = sh_t1h_q;
              tbit_d    = sh_tbit_q;
              led_num_d = byte_data_in;
              state_d   = ST_DISCARD;
            end
          endcase
        end
        ST_ADDR: begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd0) begin
            sh_addr_hi_d = byte_data_in[3:0];
          end else begin
            addr_d  = {sh_addr_hi_q, byte_data_in};
            state_d = ST_DISCARD;
          end
        end
        ST_DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = byte_data_in;
          addr_d    = addr_q + 12'd1;
        end
        ST_DISCARD: state_d = ST_DISCARD;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      sh_t0h_q     <= 8'h00;
      sh_t1h_q     <= 8'h00;
      sh_tbit_q    <= 8'h00;
      sh_addr_hi_q <= 4'h0;
      addr_q       <= 12'h000;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 12'h000;
      wr_data_q    <= 8'h00;
      refresh_q    <= 1'b0;
      t0h_q        <= T0H_RST;
      t1h_q        <= T1H_RST;
      tbit_q       <= TBIT_RST;
      led_num_q    <= LED_NUM_RST;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_t0h_q     <= sh_t0h_d;
      sh_t1h_q     <= sh_t1h_d;
      sh_tbit_q    <= sh_tbit_d;
      sh_addr_hi_q <= sh_addr_hi_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      refresh_q    <= refresh_d;
      t0h_q        <= t0h_d;
      t1h_q        <= t1h_d;
      tbit_q       <= tbit_d;
      led_num_q    <= led_num_d;
    end
  end

  assign ram_wr_en_out   = wr_en_q;
  assign ram_wr_addr_out = wr_addr_q;
  assign ram_wr_data_out = wr_data_q;
  assign refresh_out     = refresh_q;
  assign t0h_time_out    = t0h_q;
  assign t1h_time_out    = t1h_q;
  assign tbit_time_out   = tbit_q;
  assign led_num_out     = led_num_q;

endmodule

// File: doc/spi_cmd_parser.md
SPI_CMD_PARSER -- requirements
Module: spi_cmd_parser

Interface
REQ-001 Ports: clk_in  in  1  sole clock; all logic on its rising edge.
REQ-002 Ports: rst_n_in  in  1  asynchronous, active-low reset.
REQ-003 Ports: spi_cs_in  in  1  frame-active level, already synchronised to clk_in; 1 = CS asserted.
REQ-004 Ports: byte_rdy_in  in  1  one-cycle strobe; byte_data_in is valid in that cycle.
REQ-005 Ports: byte_data_in  in  8  received SPI byte, MSB first on the wire.
REQ-006 Ports: ram_wr_en_out  out  1  one-cycle LED-RAM write strobe.
REQ-007 Ports: ram_wr_addr_out  out  12  LED-RAM byte address.
REQ-008 Ports: ram_wr_data_out  out  8  LED-RAM write data.
REQ-009 Ports: t0h_time_out, t1h_time_out, tbit_time_out  out  8 each  bit-timing config, in clk_in cycles.
REQ-010 Ports: led_num_out  out  8  configured LED count.
REQ-011 Ports: refresh_out  out  1  one-cycle "start output frame" pulse.

Function
REQ-012 The block SHALL implement states IDLE, CONF, ADDR, DATA and DISCARD, and SHALL act only on cycles where byte_rdy_in=1 and spi_cs_in=1.
REQ-013 In IDLE, the first byte of a frame SHALL be decoded as follows:
- 0x2A -> CONF.
- 0x2B -> ADDR.
- 0x2C -> DATA.
- 0x2D -> pulse refresh_out in the next cycle and go to DISCARD.
- any other value -> DISCARD.
REQ-014 CONF SHALL collect 4 bytes in the order t0h, t1h, tbit, led_num using a 2-bit byte counter.
REQ-015 All four config outputs SHALL update together in the cycle after the 4th byte; CONF SHALL then go to DISCARD.
REQ-016 A CONF sequence cut short by CS deassertion SHALL leave all config outputs unchanged.
REQ-017 ADDR SHALL collect 2 bytes, big-endian, and load bits [11:0] into the address register after the 2nd byte; it SHALL then go to DISCARD.
REQ-018 A partial ADDR sequence SHALL leave the address register unchanged.
REQ-019 For each byte in DATA, ram_wr_en_out SHALL be 1 for exactly one cycle, in the cycle after byte_rdy_in, with ram_wr_data_out = the byte and ram_wr_addr_out = the current address.
REQ-020 After each DATA write, the address register SHALL increment by 1, wrapping 0xFFF -> 0x000.
REQ-021 DATA SHALL continue until CS is deasserted; there is no length limit.
REQ-022 DISCARD SHALL ignore all bytes until CS is deasserted.
REQ-023 spi_cs_in=0 SHALL force IDLE on the next edge and clear the byte counter, with priority over any coincident byte_rdy_in.
REQ-024 The address register SHALL persist across frames, so a new DATA frame resumes at the last address.
REQ-025 ram_wr_en_out and refresh_out SHALL be registered, and 0 in every cycle not specified above.
REQ-026 ram_wr_addr_out and ram_wr_data_out SHALL hold their last values when ram_wr_en_out=0.

Reset
REQ-027 While rst_n_in=0, the block SHALL be in IDLE with the byte counter at 0 and shadow registers at 0.
REQ-028 While rst_n_in=0, outputs SHALL be: ram_wr_en_out=0, ram_wr_addr_out=0x000, ram_wr_data_out=0x00, refresh_out=0.
REQ-029 While rst_n_in=0, config outputs SHALL be: t0h=8'd10, t1h=8'd30, tbit=8'd60, led_num=8'd64.
REQ-030 Reset asserted mid-frame SHALL abort any partial command with no write or refresh emitted.

Structure
REQ-031 Package spi_cmd_pkg SHALL hold the command codes (CONF_WR 0x2A, ADDR_WR 0x2B, DATA_WR 0x2C, REFRESH 0x2D), the state enum, and the reset-default config constants.
REQ-032 The block SHALL be a single module with no sub-modules; config staging SHALL use shadow registers local to the module.

Verification
REQ-033 Frame {2A,05,0F,1E,20} -> exactly one config update: t0h=5, t1h=15, tbit=30, led_num=32.
REQ-034 Frame {2B,0F,FE}, then new frame {2C,AA,BB,CC} -> writes (0xFFE,AA), (0xFFF,BB), (0x000,CC), each strobe one cycle after its byte_rdy_in.
REQ-035 Frame {2A,01,02} aborted by CS deassertion -> config stays at reset defaults; no RAM write.
REQ-036 Frame {2D,11,22} -> single refresh_out pulse one cycle after the first byte; no RAM writes.
REQ-037 Frame {7F,2C,55} -> no write and no refresh; the next frame {2C,55} writes 0x55 at the persisted address.
REQ-038 rst_n_in pulsed low after {2C,AA} -> all outputs at reset values; the following frame {2C,01} writes to 0x000.
